dpram_fifo_ctrl: RTL and testbench

DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

---
 rtl/dpram_fifo_ctrl.sv | 144 ++++++++++++++
 tb/tb_dpram_fifo_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller for an external registered-read dual-port RAM, with a two-entry output buffer.
// Optional sticky overflow/underflow flags are built only when DPRAM_FIFO_ERR_FLAG_EN is defined.
module dpram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  sync_reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  output logic                  dout_valid,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  dout_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  overflow,
  output logic                  underflow,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_write_en,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr, rptr, raddr_hold;
  logic [ADDR_WIDTH:0]   ram_count, ram_count_nxt;
  logic                  pending;
  logic                  head_valid, skid_valid;
  logic [DATA_WIDTH-1:0] head_data, skid_data;
  logic                  head_valid_nxt, skid_valid_nxt;
  logic [DATA_WIDTH-1:0] head_data_nxt, skid_data_nxt;
  logic [ADDR_WIDTH+1:0] level_q, level_nxt;
  logic                  full_i, accept, pop, issue;
  logic [2:0]            slots_after_pop;
  logic [ADDR_WIDTH-1:0] raddr_i;

  assign full_i = (ram_count == DEPTH_CNT);
  assign accept = push & ~full_i & ~sync_reset;
  assign pop    = head_valid & dout_ready & ~sync_reset;

  // Buffer slots still claimed after this cycle's pop; a pop implies head_valid, so no wrap.
  assign slots_after_pop = {2'b00, head_valid} + {2'b00, skid_valid} + {2'b00, pending}
                         - {2'b00, pop};
  assign issue = (ram_count != '0) & (slots_after_pop < 3'd2) & ~sync_reset;

  assign raddr_i = issue ? rptr : raddr_hold;

  always_comb begin
    ram_count_nxt = ram_count;
    case ({accept, issue})
      2'b10:   ram_count_nxt = ram_count + 1'b1;
      2'b01:   ram_count_nxt = ram_count - 1'b1;
      default: ram_count_nxt = ram_count;
    endcase
  end

  always_comb begin
    head_valid_nxt = head_valid;
    head_data_nxt  = head_data;
    skid_valid_nxt = skid_valid;
    skid_data_nxt  = skid_data;
    if (pop) begin
      head_valid_nxt = skid_valid;
      head_data_nxt  = skid_data;
      skid_valid_nxt = 1'b0;
    end
    // Returning RAM word lands in the first entry left free after the pop shift.
    if (pending) begin
      if (!head_valid_nxt) begin
        head_valid_nxt = 1'b1;
        head_data_nxt  = ram_dout;
      end else begin
        skid_valid_nxt = 1'b1;
        skid_data_nxt  = ram_dout;
      end
    end
  end

  always_comb begin
    level_nxt = {1'b0, ram_count_nxt}
              + {{(ADDR_WIDTH+1){1'b0}}, head_valid_nxt}
              + {{(ADDR_WIDTH+1){1'b0}}, skid_valid_nxt}
              + {{(ADDR_WIDTH+1){1'b0}}, issue};
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      wptr       <= '0;
      rptr       <= '0;
      raddr_hold <= '0;
      ram_count  <= '0;
      pending    <= 1'b0;
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      head_data  <= '0;
      skid_data  <= '0;
      level_q    <= '0;
    end else begin
      if (accept) wptr <= wptr + 1'b1;
      if (issue)  rptr <= rptr + 1'b1;
      raddr_hold <= raddr_i;
      ram_count  <= ram_count_nxt;
      pending    <= issue;
      head_valid <= head_valid_nxt;
      head_data  <= head_data_nxt;
      skid_valid <= skid_valid_nxt;
      skid_data  <= skid_data_nxt;
      level_q    <= level_nxt;
    end
  end

  // Outputs are forced to their idle values for the whole reset cycle, not just after it.
  assign full         = full_i & ~sync_reset;
  assign dout_valid   = head_valid & ~sync_reset;
  assign dout         = sync_reset ? '0 : head_data;
  assign level        = sync_reset ? '0 : level_q;
  assign ram_write_en = accept;
  assign ram_waddr    = sync_reset ? '0 : wptr;
  assign ram_din      = push_data;
  assign ram_raddr    = sync_reset ? '0 : raddr_i;

`ifdef DPRAM_FIFO_ERR_FLAG_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push & full_i)            overflow_q  <= 1'b1;
      if (dout_ready & ~head_valid) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Directed bench for dpram_fifo_ctrl (ADDR_WIDTH=2, DATA_WIDTH=8) with a registered-read RAM model.
module tb_dpram_fifo_ctrl;
  localparam int AW = 2;
  localparam int DW = 8;
`ifdef DPRAM_FIFO_ERR_FLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          sync_reset, push, dout_ready;
  logic [DW-1:0] push_data, dout, ram_din, ram_dout;
  logic          full, dout_valid, overflow, underflow, ram_write_en;
  logic [AW+1:0] level;
  logic [AW-1:0] ram_waddr, ram_raddr;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  int            wr_cnt = 0;
  int            n_vec = 0;
  int            n_err = 0;
  logic [DW-1:0] got_q[$];
  int            gotc_q[$];

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .sync_reset(sync_reset), .push(push), .push_data(push_data),
    .full(full), .dout_valid(dout_valid), .dout(dout), .dout_ready(dout_ready),
    .level(level), .overflow(overflow), .underflow(underflow),
    .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_din(ram_din),
    .ram_write_en(ram_write_en), .ram_dout(ram_dout)
  );

  always @(posedge clk) begin
    if (ram_write_en) begin
      mem[ram_waddr] <= ram_din;
      wr_cnt <= wr_cnt + 1;
    end
    ram_dout <= mem[ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    sync_reset = 1'b1;
    push       = 1'b1;
    push_data  = 8'hEE;
    dout_ready = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("rst_valid", dout_valid, 0);
      chk("rst_full",  full, 0);
      chk("rst_level", level, 0);
      chk("rst_we",    ram_write_en, 0);
      chk("rst_dout",  dout, 0);
      chk("rst_waddr", ram_waddr, 0);
      chk("rst_raddr", ram_raddr, 0);
      tick();
    end
    sync_reset = 1'b0;
    push       = 1'b0;
  endtask

  // Pushes npush words (base, base+1, ...) honouring full, collects pops until nexp words seen.
  task automatic stream(input int npush, input int nexp, input logic [DW-1:0] base, input bit toggle);
    int sent = 0;
    got_q.delete();
    gotc_q.delete();
    for (int c = 0; c < 200 && got_q.size() < nexp; c++) begin
      dout_ready = toggle ? ~c[0] : 1'b1;
      if (sent < npush && !full) begin
        push      = 1'b1;
        push_data = base + DW'(sent);
        sent++;
      end else begin
        push = 1'b0;
      end
      @(negedge clk);
      if (dout_valid && dout_ready) begin
        got_q.push_back(dout);
        gotc_q.push_back(c);
      end
      tick();
    end
    push       = 1'b0;
    dout_ready = 1'b0;
    chk("stream_count", got_q.size(), nexp);
    for (int i = 0; i < got_q.size(); i++)
      chk($sformatf("stream_data[%0d]", i), got_q[i], base + DW'(i));
  endtask

  initial begin
    push_data  = '0;
    do_reset(2);
    @(negedge clk);
    chk("post_rst_ovf", overflow, 0);
    chk("post_rst_unf", underflow, 0);
    tick();

    // single word, ready held high
    push = 1'b1; push_data = 8'hA5; dout_ready = 1'b1;
    @(negedge clk);
    chk("sw_we", ram_write_en, 1);
    chk("sw_waddr", ram_waddr, 0);
    chk("sw_din", ram_din, 8'hA5);
    tick();
    push = 1'b0;
    @(negedge clk); chk("sw_c1_level", level, 1); chk("sw_c1_valid", dout_valid, 0); tick();
    @(negedge clk); chk("sw_c2_valid", dout_valid, 0); tick();
    @(negedge clk); chk("sw_c3_valid", dout_valid, 1); chk("sw_c3_dout", dout, 8'hA5); tick();
    @(negedge clk);
    chk("sw_c4_level", level, 0);
    chk("sw_c4_valid", dout_valid, 0);
    chk("sw_unf", underflow, ERR_EN);
    tick();

    // fill with ready low, then push while full
    do_reset(1);
    begin
      int wr0;
      wr0 = wr_cnt;
      for (int i = 0; i < 6; i++) begin
        push = 1'b1; push_data = DW'(i + 1);
        @(negedge clk);
        tick();
      end
      push = 1'b1; push_data = 8'h07;
      @(negedge clk);
      chk("fill_full", full, 1);
      chk("fill_level", level, 6);
      chk("fill_we_blocked", ram_write_en, 0);
      chk("fill_writes", wr_cnt - wr0, 6);
      tick();
      push = 1'b0;
      @(negedge clk);
      chk("fill_ovf", overflow, ERR_EN);
      chk("fill_level_hold", level, 6);
      chk("fill_writes_after", wr_cnt - wr0, 6);
      tick();
    end
    stream(0, 6, 8'h01, 1'b0);
    @(negedge clk);
    chk("drain_level", level, 0);
    chk("drain_ovf_sticky", overflow, ERR_EN);
    tick();

    // streaming across four pointer wraps
    do_reset(1);
    stream(16, 16, 8'h00, 1'b0);
    if (gotc_q.size() > 0) chk("stream_first_cycle", gotc_q[0], 3);
    for (int i = 1; i < gotc_q.size(); i++)
      chk($sformatf("stream_gap[%0d]", i), gotc_q[i] - gotc_q[i-1], 1);

    // backpressure 1010...
    do_reset(1);
    stream(10, 10, 8'h20, 1'b1);

    // reset mid-stream at level 5
    do_reset(1);
    for (int i = 0; i < 5; i++) begin
      push = 1'b1; push_data = 8'h50 + DW'(i);
      @(negedge clk);
      tick();
    end
    push = 1'b0;
    @(negedge clk); chk("mid_level5", level, 5); tick();
    sync_reset = 1'b1; push = 1'b1; push_data = 8'h99;
    @(negedge clk);
    chk("mid_rst_valid", dout_valid, 0);
    chk("mid_rst_we", ram_write_en, 0);
    tick();
    sync_reset = 1'b0; push = 1'b1; push_data = 8'h77;
    @(negedge clk);
    chk("mid_level0", level, 0);
    chk("mid_valid0", dout_valid, 0);
    chk("mid_full0", full, 0);
    tick();
    push = 1'b0;
    @(negedge clk); chk("mid_c1_level", level, 1); tick();
    @(negedge clk); chk("mid_c2_valid", dout_valid, 0); tick();
    @(negedge clk); chk("mid_c3_valid", dout_valid, 1); chk("mid_c3_dout", dout, 8'h77); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
